// File: rtl/alu_op_decoder.sv
// Decodes RV32I OP/OP-IMM/LUI/AUIPC into ALU operands and control, presented
// through a two-entry skid buffer with a fully registered in_ready.
module alu_op_decoder #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [4:0]      rd;
        logic            we;
        logic            ill;
    } entry_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_in_ready;
    entry_t     r_head;
    entry_t     r_skid;
    entry_t     w_dec;
    logic       w_legal;
    logic       w_in_fire;
    logic       w_out_fire;
    logic       w_load_head;
    logic       w_promote_skid;
    logic       w_load_skid;

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [4:0] w_rd;

    assign w_opcode = instr[6:0];
    assign w_rd     = instr[11:7];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_dec    = '0;
        w_dec.rd = w_rd;
        w_legal  = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_legal  = (w_f7 == F7_ZERO) ||
                           ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
                w_dec.a  = rs1_data;
                w_dec.b  = rs2_data;
                w_dec.f3 = w_f3;
                w_dec.f7 = w_f7;
            end
            OPC_OP_IMM: begin
                w_dec.a  = rs1_data;
                w_dec.f3 = w_f3;
                if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
                    w_legal  = (w_f7 == F7_ZERO) || ((w_f7 == F7_ALT) && (w_f3 == 3'b101));
                    w_dec.b  = {{(XLEN-5){1'b0}}, instr[24:20]};
                    w_dec.f7 = w_f7;
                end else begin
                    // funct7 stays zero so an immediate with bit 30 set never turns ADDI into SUB
                    w_legal = 1'b1;
                    w_dec.b = {{(XLEN-12){instr[31]}}, instr[31:20]};
                end
            end
            OPC_LUI: begin
                w_legal = 1'b1;
                w_dec.b = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                w_legal = 1'b1;
                w_dec.a = pc;
                w_dec.b = {instr[31:12], 12'b0};
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_dec.a  = '0;
            w_dec.b  = '0;
            w_dec.f3 = '0;
            w_dec.f7 = '0;
        end
        w_dec.ill = !w_legal;
        w_dec.we  = w_legal && (w_rd != 5'd0);
    end

    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = (r_state != S_EMPTY) && out_ready;

    always_comb begin
        w_state_next   = r_state;
        w_load_head    = 1'b0;
        w_promote_skid = 1'b0;
        w_load_skid    = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_state_next = S_ONE;
                    w_load_head  = 1'b1;
                end
            end
            S_ONE: begin
                case ({w_in_fire, w_out_fire})
                    2'b10: begin
                        w_state_next = S_TWO;
                        w_load_skid  = 1'b1;
                    end
                    2'b01: w_state_next = S_EMPTY;
                    2'b11: w_load_head  = 1'b1;
                    default: ;
                endcase
            end
            S_TWO: begin
                if (w_out_fire) begin
                    w_state_next   = S_ONE;
                    w_promote_skid = 1'b1;
                end
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    // in_ready is its own flop so it reads 0 throughout reset and rises one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b0;
            r_head     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != S_TWO);
            if (w_load_head) begin
                r_head <= w_dec;
            end else if (w_promote_skid) begin
                r_head <= r_skid;
            end
        end
    end

    // NOTE: the skid slot has no reset; it is only read after being written in ONE.
    always_ff @(posedge clk) begin
        if (w_load_skid) begin
            r_skid <= w_dec;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = (r_state != S_EMPTY);
    assign alu_a      = r_head.a;
    assign alu_b      = r_head.b;
    assign alu_funct3 = r_head.f3;
    assign alu_funct7 = r_head.f7;
    assign rd         = r_head.rd;
    assign rd_we      = r_head.we;
    assign illegal    = r_head.ill;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder: a reference decode is queued on every
// accepted input and compared against the presented entry each cycle.
module tb_alu_op_decoder;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    // Directed cases: instruction, operands, and hand-derived expected decode.
    logic [31:0] t_instr [12] = '{32'h002081B3, 32'h402081B3, 32'h40435293, 32'hFFF00093,
                                  32'h123450B7, 32'h00001117, 32'h0000007F, 32'h022081B3,
                                  32'h00208033, 32'h402091B3, 32'h40431293, 32'h40030293};
    logic [31:0] t_rs1   [12] = '{32'd5, 32'd9, 32'hFFFFFFF0, 32'h11, 32'h11, 32'd1, 32'd5,
                                  32'd5, 32'd5, 32'd5, 32'd5, 32'd7};
    logic [31:0] t_rs2   [12] = '{32'd3, 32'd4, 32'd7, 32'h22, 32'h22, 32'd2, 32'd6,
                                  32'd3, 32'd3, 32'd3, 32'd3, 32'd8};
    logic [31:0] t_pc    [12] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h40, 32'h1000, 32'h0,
                                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] g_a     [12] = '{32'd5, 32'd9, 32'hFFFFFFF0, 32'h11, 32'h0, 32'h1000, 32'h0,
                                  32'h0, 32'd5, 32'h0, 32'h0, 32'd7};
    logic [31:0] g_b     [12] = '{32'd3, 32'd4, 32'd4, 32'hFFFFFFFF, 32'h12345000, 32'h1000,
                                  32'h0, 32'h0, 32'd3, 32'h0, 32'h0, 32'h400};
    logic [2:0]  g_f3    [12] = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                                  3'd0, 3'd0, 3'd0};
    logic [6:0]  g_f7    [12] = '{7'h00, 7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                                  7'h00, 7'h00, 7'h00, 7'h00};
    logic [4:0]  g_rd    [12] = '{5'd3, 5'd3, 5'd5, 5'd1, 5'd1, 5'd2, 5'd0, 5'd3, 5'd0,
                                  5'd3, 5'd5, 5'd5};
    logic        g_we    [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b1};
    logic        g_ill   [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                  1'b1, 1'b1, 1'b0};

    alu_op_decoder #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .pc         (pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_funct3 (alu_funct3),
        .alu_funct7 (alu_funct7),
        .rd         (rd),
        .rd_we      (rd_we),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference decode, written from the instruction-format point of view.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic [31:0] p);
        exp_t e;
        logic ok;
        e    = '0;
        ok   = 1'b0;
        e.rd = ins[11:7];
        if (ins[6:0] == 7'h33) begin
            ok = (ins[31:25] == 7'h00) ||
                 (ins[31:25] == 7'h20 && (ins[14:12] == 3'd0 || ins[14:12] == 3'd5));
            if (ok) begin
                e.a = r1; e.b = r2; e.f3 = ins[14:12]; e.f7 = ins[31:25];
            end
        end else if (ins[6:0] == 7'h13) begin
            if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) begin
                ok = (ins[31:25] == 7'h00) || (ins[31:25] == 7'h20 && ins[14:12] == 3'd5);
                if (ok) begin
                    e.a = r1; e.b = 32'(ins[24:20]); e.f3 = ins[14:12]; e.f7 = ins[31:25];
                end
            end else begin
                ok = 1'b1;
                e.a = r1; e.b = 32'($signed(ins[31:20])); e.f3 = ins[14:12];
            end
        end else if (ins[6:0] == 7'h37) begin
            ok = 1'b1;
            e.b = {ins[31:12], 12'h000};
        end else if (ins[6:0] == 7'h17) begin
            ok = 1'b1;
            e.a = p; e.b = {ins[31:12], 12'h000};
        end
        e.ill = !ok;
        e.we  = ok && (ins[11:7] != 5'd0);
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.a = alu_a; o.b = alu_b; o.f3 = alu_funct3; o.f7 = alu_funct7;
        o.rd = rd; o.we = rd_we; o.ill = illegal;
        return o;
    endfunction

    // One clock: score the presented entry, record any accepted input, advance to next negedge.
    task automatic cycle();
        exp_t e;
        exp_t o;
        if (out_valid === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_spurious: out_valid=1 but no entry expected");
            end else begin
                e = sb_q[0];
                o = observed();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL sb_entry: got a=%h b=%h f3=%h f7=%h rd=%0d we=%b ill=%b, want a=%h b=%h f3=%h f7=%h rd=%0d we=%b ill=%b",
                             o.a, o.b, o.f3, o.f7, o.rd, o.we, o.ill,
                             e.a, e.b, e.f3, e.f7, e.rd, e.we, e.ill);
                end
                if (out_ready && !reset) void'(sb_q.pop_front());
            end
        end
        if (!reset && in_valid && in_ready === 1'b1)
            sb_q.push_back(model(instr, rs1_data, rs2_data, pc));
        if (reset) sb_q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int i);
        instr    = t_instr[i];
        rs1_data = t_rs1[i];
        rs2_data = t_rs2[i];
        pc       = t_pc[i];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if ({out_valid, in_ready, alu_a, alu_b, alu_funct3, alu_funct7, rd, rd_we, illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: out_valid=%b in_ready=%b a=%h b=%h, want all zero",
                     out_valid, in_ready, alu_a, alu_b);
        end
        reset = 1'b0;
        cycle();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_decode();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(i);
            in_valid = 1'b1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL decode_ready%0d: in_ready=%b, want 1", i, in_ready);
            end
            cycle();
            in_valid = 1'b0;
            n_checks++;
            if ({out_valid, alu_a, alu_b, alu_funct3, alu_funct7, rd, rd_we, illegal} !==
                {1'b1, g_a[i], g_b[i], g_f3[i], g_f7[i], g_rd[i], g_we[i], g_ill[i]}) begin
                n_fail++;
                $display("FAIL decode%0d: got v=%b a=%h b=%h f3=%h f7=%h rd=%0d we=%b ill=%b, want a=%h b=%h f3=%h f7=%h rd=%0d we=%b ill=%b",
                         i, out_valid, alu_a, alu_b, alu_funct3, alu_funct7, rd, rd_we, illegal,
                         g_a[i], g_b[i], g_f3[i], g_f7[i], g_rd[i], g_we[i], g_ill[i]);
            end
            cycle();
        end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        instr = 32'h002081B3; rs1_data = 32'd100; rs2_data = 32'd1; pc = 32'h0;
        in_valid = 1'b1;
        cycle();
        rs1_data = 32'd101;
        cycle();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL skid_full: in_ready=%b, want 0", in_ready);
        end
        rs1_data = 32'd102;
        cycle();
        cycle();
        n_checks++;
        if (in_ready !== 1'b0 || alu_a !== 32'd100) begin
            n_fail++;
            $display("FAIL skid_hold: in_ready=%b a=%0d, want 0 100", in_ready, alu_a);
        end
        out_ready = 1'b1;
        cycle();
        n_checks++;
        if (in_ready !== 1'b1 || alu_a !== 32'd101 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_promote: in_ready=%b v=%b a=%0d, want 1 1 101", in_ready, out_valid, alu_a);
        end
        cycle();
        in_valid = 1'b0;
        n_checks++;
        if (alu_a !== 32'd102 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_third: v=%b a=%0d, want 1 102", out_valid, alu_a);
        end
        cycle();
        n_checks++;
        if (out_valid !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL skid_drain: out_valid=%b pending=%0d, want 0 0", out_valid, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(0);
        in_valid = 1'b1;
        cycle();
        drive(4);
        cycle();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_two: in_ready=%b out_valid=%b, want 0 1", in_ready, out_valid);
        end
        reset = 1'b1;
        out_ready = 1'b1;
        cycle();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: out_valid=%b in_ready=%b a=%h b=%h, want 0 0 0 0",
                     out_valid, in_ready, alu_a, alu_b);
        end
        cycle();
        reset = 1'b0;
        in_valid = 1'b0;
        cycle();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        for (int i = 0; i < 4; i++) cycle();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_stale: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int  sent;
        int  budget;
        logic acc;
        sent   = 0;
        budget = 0;
        in_valid = 1'b0;
        while (sent < 300 && budget < 4000) begin
            if (!in_valid) begin
                if ($urandom_range(0, 3) == 0) instr = $urandom();
                else instr = t_instr[$urandom_range(0, 11)];
                rs1_data = $urandom();
                rs2_data = $urandom();
                pc       = $urandom();
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 4) < 3);
            acc = in_valid && (in_ready === 1'b1);
            cycle();
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            budget++;
        end
        n_checks++;
        if (sent < 300) begin
            n_fail++;
            $display("FAIL b2b_timeout: sent=%0d, want 300", sent);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && out_valid === 1'b1; i++) cycle();
        n_checks++;
        if (out_valid !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: out_valid=%b pending=%0d, want 0 0", out_valid, sb_q.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'h0;
        rs1_data  = 32'h0;
        rs2_data  = 32'h0;
        pc        = 32'h0;
        @(negedge clk);
        test_reset();
        test_decode();
        test_skid();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
